// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect input,
// and the instruction handoff toward the decoder.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding imem requests feeding a
// 2-entry {pc, data} buffer, with redirect flush and response drain.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [1:0]  FULL = 2'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_issued_pc;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_data [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic w_req_valid;
    logic w_req_fire;
    logic w_instr_valid;
    logic w_push;
    logic w_pop;
    logic w_tail;
    logic w_unused;

    assign w_req_valid   = !reset && (r_state == S_REQ) &&
                           (r_count < FULL) && !bus.redirect_valid;
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    assign w_instr_valid = !reset && (r_count != 2'd0);
    assign w_pop         = w_instr_valid && bus.instr_ready;
    assign w_push        = (r_state == S_WAIT) && bus.imem_rsp_valid;
    // a push only happens with count<=1, so tail is head+count mod 2
    assign w_tail        = r_head ^ r_count[0];
    assign w_unused      = &{1'b0, bus.redirect_pc[1:0]};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = {r_fetch_pc[31:2], 2'b00};
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr_data     = w_instr_valid ? r_buf_data[r_head] : NOP;
    assign bus.instr_pc       = w_instr_valid ? r_buf_pc[r_head] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_fetch_pc  <= RESET_PC;
            r_issued_pc <= RESET_PC;
            r_head      <= 1'b0;
            r_count     <= 2'd0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            // an in-flight response must be swallowed before refetching
            unique case (r_state)
                S_WAIT, S_DRAIN:
                    r_state <= bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                default:
                    r_state <= S_REQ;
            endcase
        end else begin
            if (w_push) begin
                r_buf_pc[w_tail]   <= r_issued_pc;
                r_buf_data[w_tail] <= bus.imem_rsp_data;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            unique case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_issued_pc <= r_fetch_pc;
                        r_fetch_pc  <= r_fetch_pc + 32'd4;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory model with
// configurable latency, redirects, backpressure and reset.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    ent_t        sb[$];
    bit          pend;
    bit          pend_drop;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          lat;
    logic [31:0] exp_addr;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .BUF_DEPTH(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        sb.delete();
        pend      = 1'b0;
        pend_drop = 1'b0;
        pend_wait = 0;
        exp_addr  = RST_PC;
    endtask

    // called just after a falling edge; memory answers when its delay expires
    task automatic drive(input bit rdy, input bit redir,
                         input logic [31:0] rpc, input bit rreq);
        bus.instr_ready    = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rreq;
        bus.imem_rsp_valid = pend && (pend_wait == 0);
        bus.imem_rsp_data  = pend ? memf(pend_addr) : 32'h0;
        #1;
    endtask

    // update the reference model for the coming rising edge, then advance
    task automatic commit();
        bit   rsp;
        bit   acc;
        ent_t e;
        rsp = bus.imem_rsp_valid;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        if (acc) begin
            checks++;
            if (bus.imem_req_addr !== exp_addr || (pend && !rsp)) begin
                failures++;
                $display("FAIL req_issue: addr=%h want=%h outstanding=%0b",
                         bus.imem_req_addr, exp_addr, pend && !rsp);
            end
            exp_addr = exp_addr + 32'd4;
        end
        if (bus.redirect_valid) begin
            sb.delete();
            exp_addr = {bus.redirect_pc[31:2], 2'b00};
            if (pend && !rsp) pend_drop = 1'b1;
        end else begin
            if (bus.instr_valid && bus.instr_ready && sb.size() != 0)
                e = sb.pop_front();
            if (rsp && !pend_drop)
                sb.push_back({pend_addr, memf(pend_addr)});
        end
        if (rsp) begin
            pend      = 1'b0;
            pend_drop = 1'b0;
        end else if (pend && pend_wait > 0) begin
            pend_wait--;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_addr = bus.imem_req_addr;
            pend_wait = lat;
            pend_drop = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 ||
            bus.instr_data !== NOP || bus.instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: rv=%b iv=%b data=%h pc=%h",
                     bus.imem_req_valid, bus.instr_valid,
                     bus.instr_data, bus.instr_pc);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_req: rv=%b addr=%h want 1/%h",
                     bus.imem_req_valid, bus.imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] got[$];
        ent_t        w;
        do_reset();
        lat = 0;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.instr_valid) begin
                w = (sb.size() != 0) ? sb[0] : 'x;
                checks++;
                if (bus.instr_pc !== w.pc || bus.instr_data !== w.data) begin
                    failures++;
                    $display("FAIL stream_sb: pc=%h data=%h want %h/%h",
                             bus.instr_pc, bus.instr_data, w.pc, w.data);
                end
                got.push_back(bus.instr_pc);
            end
            commit();
        end
        checks++;
        if (got.size() < 4 || got[0] !== 32'h0 || got[1] !== 32'h4 ||
            got[2] !== 32'h8 || got[3] !== 32'hC) begin
            failures++;
            $display("FAIL stream_order: n=%0d want pcs 0,4,8,c", got.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        want = 32'h0;
        do_reset();
        lat = 0;
        repeat (10) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            commit();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 ||
            bus.instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_full: iv=%b rv=%b pc=%h want 1/0/0",
                     bus.instr_valid, bus.imem_req_valid, bus.instr_pc);
        end
        for (int c = 0; c < 40 && want < 32'h20; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.instr_valid) begin
                checks++;
                if (bus.instr_pc !== want || bus.instr_data !== memf(want)) begin
                    failures++;
                    $display("FAIL bp_resume: pc=%h data=%h want %h/%h",
                             bus.instr_pc, bus.instr_data, want, memf(want));
                end
                want = want + 32'd4;
            end
            commit();
        end
        checks++;
        if (want !== 32'h20) begin
            failures++;
            $display("FAIL bp_count: reached=%h want 20", want);
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        bit seen;
        found = 1'b0;
        seen  = 1'b0;
        do_reset();
        lat = 2;
        for (int c = 0; c < 40 && !found; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.imem_req_valid && bus.imem_req_addr == 32'h8) found = 1'b1;
            commit();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rw_issue8: got 0 want 1");
        end
        drive(1'b1, 1'b1, 32'h100, 1'b1);
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_noreq: rv=%b want 0", bus.imem_req_valid);
        end
        commit();
        for (int c = 0; c < 30 && !seen; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.instr_valid) begin
                seen = 1'b1;
                checks++;
                if (bus.instr_pc !== 32'h100 ||
                    bus.instr_data !== memf(32'h100)) begin
                    failures++;
                    $display("FAIL rw_target: pc=%h data=%h want 100/%h",
                             bus.instr_pc, bus.instr_data, memf(32'h100));
                end
            end
            commit();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rw_timeout: got 0 want 1");
        end
    endtask

    task automatic test_redirect_coincident();
        bit found;
        found = 1'b0;
        do_reset();
        lat = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (pend && pend_wait == 0 && sb.size() == 1) begin
                found = 1'b1;
            end else begin
                drive(1'b0, 1'b0, 32'h0, 1'b1);
                commit();
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rc_setup: got 0 want 1");
        end
        drive(1'b1, 1'b1, 32'h203, 1'b1);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rc_same: iv=%b rv=%b want 1/0",
                     bus.instr_valid, bus.imem_req_valid);
        end
        commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
            bus.imem_req_addr !== 32'h200) begin
            failures++;
            $display("FAIL rc_next: iv=%b rv=%b addr=%h want 0/1/200",
                     bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
        commit();
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        do_reset();
        lat = 1;
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        commit();
        for (int c = 0; c < 30 && got.size() < 2; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.instr_valid) begin
                checks++;
                if (bus.instr_data !== memf(bus.instr_pc)) begin
                    failures++;
                    $display("FAIL wrap_data: data=%h want %h",
                             bus.instr_data, memf(bus.instr_pc));
                end
                got.push_back(bus.instr_pc);
            end
            commit();
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pcs: n=%0d want fffffffc then 0", got.size());
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit seen;
        found = 1'b0;
        seen  = 1'b0;
        do_reset();
        lat = 3;
        for (int c = 0; c < 30 && !found; c++) begin
            if (pend && sb.size() == 1) begin
                found = 1'b1;
            end else begin
                drive(1'b0, 1'b0, 32'h0, 1'b1);
                commit();
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rm_setup: got 0 want 1");
        end
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_data !== NOP ||
            bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_flush: iv=%b data=%h rv=%b want 0/%h/0",
                     bus.instr_valid, bus.instr_data, bus.imem_req_valid, NOP);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL rm_first: rv=%b addr=%h want 1/%h",
                     bus.imem_req_valid, bus.imem_req_addr, RST_PC);
        end
        commit();
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.instr_valid) begin
                seen = 1'b1;
                checks++;
                if (bus.instr_pc !== RST_PC) begin
                    failures++;
                    $display("FAIL rm_deliver: pc=%h want %h",
                             bus.instr_pc, RST_PC);
                end
            end
            commit();
        end
    endtask

    task automatic test_random();
        bit   rdy;
        bit   rreq;
        bit   redir;
        bit   prev_hold;
        ent_t w;
        prev_hold = 1'b0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            lat   = $urandom_range(0, 2);
            rdy   = ($urandom_range(0, 3) != 0);
            rreq  = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            drive(rdy, redir, $urandom(), rreq);
            w = (sb.size() != 0) ? sb[0] : 'x;
            checks++;
            if (bus.instr_valid !== (sb.size() != 0) ||
                (bus.instr_valid &&
                 (bus.instr_pc !== w.pc || bus.instr_data !== w.data))) begin
                failures++;
                $display("FAIL rand_head: iv=%b pc=%h data=%h want n=%0d %h/%h",
                         bus.instr_valid, bus.instr_pc, bus.instr_data,
                         sb.size(), w.pc, w.data);
            end
            if (prev_hold && !redir) begin
                checks++;
                if (bus.imem_req_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_retract: rv=%b want 1",
                             bus.imem_req_valid);
                end
            end
            prev_hold = bus.imem_req_valid && !bus.imem_req_ready;
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
